// File: rtl/sadd_result_collector_if.sv
// rtl/sadd_result_collector_if.sv - serial sum stream in, parallel result word handshake out
interface sadd_result_collector_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             bit_valid;
   logic             sum_bit;
   logic             carry_bit;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_valid;
   logic             res_ready;

   modport master (
      output start, bit_valid, sum_bit, carry_bit, res_ready,
      input  res_data, res_carry, res_valid
   );

   modport slave (
      input  start, bit_valid, sum_bit, carry_bit, res_ready,
      output res_data, res_carry, res_valid
   );
endinterface

// File: rtl/sadd_result_collector.sv
// rtl/sadd_result_collector.sv - reassembles LSB-first serial sums into words behind a small FWFT buffer
module sadd_result_collector #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   sadd_result_collector_if.slave sif,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow_err,
   input  logic                   clr_err
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   done_word;
   logic             done_valid;
   logic [WIDTH:0]   mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   logic last_bit;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      last_bit = (state == COLLECT) && !sif.start && sif.bit_valid && (cnt == CW'(WIDTH - 1));
      full     = (count == (PW + 1)'(DEPTH));
      pop      = sif.res_valid && sif.res_ready;
      // A full buffer still takes the completed word when the head leaves in the same cycle.
      push     = done_valid && (!full || pop);
      drop     = done_valid && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         shreg        <= '0;
         cnt          <= '0;
         done_word    <= '0;
         done_valid   <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         done_valid <= last_bit;
         if (last_bit)
            done_word <= {sif.carry_bit, sif.sum_bit, shreg[WIDTH-1:1]};

         case (state)
            IDLE: begin
               if (sif.start) begin
                  state <= COLLECT;
                  shreg <= '0;
                  cnt   <= '0;
               end
            end
            COLLECT: begin
               if (sif.start) begin
                  shreg <= '0;
                  cnt   <= '0;
               end else if (sif.bit_valid) begin
                  shreg <= {sif.sum_bit, shreg[WIDTH-1:1]};
                  if (last_bit) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (push) begin
            mem[wr_ptr] <= done_word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop)
            overflow_err <= 1'b1;
         else if (clr_err)
            overflow_err <= 1'b0;
      end
   end

   assign sif.res_valid = (count != '0);
   assign sif.res_data  = sif.res_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
   assign sif.res_carry = sif.res_valid ? mem[rd_ptr][WIDTH] : 1'b0;
   assign busy          = (state == COLLECT);
   assign level         = count;
endmodule

// File: tb/tb_sadd_result_collector.sv
// tb/tb_sadd_result_collector.sv - bench for sadd_result_collector
module tb_sadd_result_collector;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr_err = 1'b0;
   logic       busy;
   logic [1:0] level;
   logic       overflow_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   sadd_result_collector_if #(.WIDTH(WIDTH)) sif ();

   sadd_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .sif          (sif),
      .busy         (busy),
      .level        (level),
      .overflow_err (overflow_err),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   // Reference: words accumulated arithmetically, buffer kept as queues.
   bit m_coll = 0;
   int m_nbits = 0;
   int m_val = 0;
   bit m_pend = 0;
   int m_pword = 0;
   bit m_pcarry = 0;
   bit m_err = 0;
   int q_data[$];
   bit q_carry[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      bit popped;
      bit was_full;
      bit dropped;
      if (!rst) begin
         m_coll = 0; m_nbits = 0; m_val = 0; m_pend = 0; m_err = 0;
         q_data.delete(); q_carry.delete();
         return;
      end
      was_full = (q_data.size() == DEPTH);
      popped   = (q_data.size() > 0) && sif.res_ready;
      dropped  = 0;
      if (popped) begin
         void'(q_data.pop_front());
         void'(q_carry.pop_front());
      end
      if (m_pend) begin
         if (!was_full || popped) begin
            q_data.push_back(m_pword);
            q_carry.push_back(m_pcarry);
         end else begin
            dropped = 1;
         end
      end
      if (dropped) m_err = 1;
      else if (clr_err) m_err = 0;
      m_pend = 0;
      if (m_coll) begin
         if (sif.start) begin
            m_nbits = 0; m_val = 0;
         end else if (sif.bit_valid) begin
            m_val = m_val + (int'(sif.sum_bit) << m_nbits);
            m_nbits++;
            if (m_nbits == WIDTH) begin
               m_pend = 1; m_pword = m_val; m_pcarry = sif.carry_bit; m_coll = 0;
            end
         end
      end else if (sif.start) begin
         m_coll = 1; m_nbits = 0; m_val = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("res_valid", sif.res_valid, q_data.size() != 0);
         chk("res_data", sif.res_data, q_data.size() != 0 ? q_data[0] : 0);
         chk("res_carry", sif.res_carry, q_data.size() != 0 ? q_carry[0] : 0);
         chk("busy", busy, m_coll);
         chk("level", level, q_data.size());
         chk("overflow_err", overflow_err, m_err);
      end
   end

   task automatic send_word(input logic [7:0] w, input bit c, input bit gap);
      sif.start = 1; sif.bit_valid = 0;
      tick();
      sif.start = 0;
      chk("busy_after_start", busy, 1);
      for (int i = 0; i < WIDTH; i++) begin
         if (gap) begin
            sif.bit_valid = 0;
            tick();
            chk("busy_gap", busy, 1);
         end
         sif.bit_valid = 1;
         sif.sum_bit   = w[i];
         sif.carry_bit = (i == WIDTH - 1) ? c : 1'($urandom);
         tick();
         chk("busy_bit", busy, i < WIDTH - 1);
      end
      sif.bit_valid = 0;
   endtask

   task automatic pop_one();
      sif.res_ready = 1;
      tick();
      sif.res_ready = 0;
   endtask

   initial begin
      sif.start = 0; sif.bit_valid = 0; sif.sum_bit = 0; sif.carry_bit = 0; sif.res_ready = 0;
      rst = 0;
      tick();
      cmp_en = 1;
      for (int i = 0; i < 6; i++) begin
         sif.start = 1'($urandom); sif.bit_valid = 1'($urandom);
         sif.sum_bit = 1'($urandom); sif.res_ready = 1'($urandom);
         tick();
         chk("rst_valid", sif.res_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_level", level, 0);
         chk("rst_err", overflow_err, 0);
         chk("rst_data", sif.res_data, 8'h00);
      end
      sif.start = 0; sif.bit_valid = 0; sif.res_ready = 0;
      rst = 1;
      tick();

      send_word(8'hFF, 0, 0);
      chk("lat_valid_low", sif.res_valid, 0);
      tick();
      chk("lat_valid_high", sif.res_valid, 1);
      chk("w1_data", sif.res_data, 8'hFF);
      chk("w1_carry", sif.res_carry, 0);
      chk("w1_level", level, 1);
      chk("model_w1", q_data[0], 8'hFF);
      pop_one();

      send_word(8'h00, 1, 1);
      tick();
      chk("gap_data", sif.res_data, 8'h00);
      chk("gap_carry", sif.res_carry, 1);
      chk("gap_valid", sif.res_valid, 1);
      pop_one();
      chk("gap_empty", level, 0);

      send_word(8'h3C, 0, 0);
      send_word(8'hC3, 1, 0);
      send_word(8'h5A, 0, 0);
      tick();
      chk("ovf_level", level, 2);
      chk("ovf_err", overflow_err, 1);
      chk("model_ovf_err", m_err, 1);
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("clr_err", overflow_err, 0);
      send_word(8'h77, 0, 0);
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("set_wins", overflow_err, 1);
      chk("ovf_head0", sif.res_data, 8'h3C);
      pop_one();
      chk("ovf_head1", sif.res_data, 8'hC3);
      chk("ovf_head1_carry", sif.res_carry, 1);
      pop_one();
      chk("ovf_drained", level, 0);
      clr_err = 1;
      tick();
      clr_err = 0;

      send_word(8'h11, 0, 0);
      send_word(8'h22, 0, 0);
      send_word(8'h33, 0, 0);
      sif.res_ready = 1;
      tick();
      sif.res_ready = 0;
      chk("fp_level", level, 2);
      chk("fp_err", overflow_err, 0);
      chk("fp_head0", sif.res_data, 8'h22);
      pop_one();
      chk("fp_head1", sif.res_data, 8'h33);
      pop_one();

      sif.start = 1;
      tick();
      sif.start = 0;
      for (int i = 0; i < 4; i++) begin
         sif.bit_valid = 1; sif.sum_bit = 1'($urandom);
         tick();
      end
      sif.bit_valid = 0;
      send_word(8'h81, 0, 0);
      tick();
      chk("abort_level", level, 1);
      chk("abort_data", sif.res_data, 8'h81);
      pop_one();

      sif.start = 1;
      tick();
      sif.start = 0;
      for (int i = 0; i < 3; i++) begin
         sif.bit_valid = 1; sif.sum_bit = 1'($urandom);
         tick();
      end
      rst = 0;
      tick();
      rst = 1;
      chk("midrst_busy", busy, 0);
      chk("midrst_level", level, 0);
      for (int i = 0; i < 10; i++) begin
         sif.bit_valid = 1; sif.sum_bit = 1'($urandom); sif.carry_bit = 1'($urandom);
         tick();
      end
      sif.bit_valid = 0;
      chk("midrst_no_emit", level, 0);
      chk("midrst_no_valid", sif.res_valid, 0);

      for (int i = 0; i < 3000; i++) begin
         sif.start     = m_coll ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0);
         sif.bit_valid = ($urandom_range(0, 9) < 6);
         sif.sum_bit   = 1'($urandom);
         sif.carry_bit = 1'($urandom);
         sif.res_ready = ($urandom_range(0, 9) < 4);
         clr_err       = ($urandom_range(0, 19) == 0);
         rst           = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst = 1; sif.start = 0; sif.bit_valid = 0; sif.res_ready = 0; clr_err = 0;
      tick();
      tick();
      cmp_en = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
